regfile_mp: RTL

- Parametrised multi-port integer register file for the RV32I+P core. Successor to the single-write, two-read regfile.
- Provides NR combinational read ports and NW synchronous write ports, with optional write-through bypass.
- Adds a per-register busy scoreboard with an in-flight counter, used by issue logic to stall on long-latency (multi-cycle P-extension) results.
- Sits between decode/issue and the writeback stage(s).

---
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_mp.sv | 77 +++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: issue/writeback bus of the multi-port register file; REGFILE_PAIR_EN adds pair-write signals
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NR    = 3,
  parameter int NW    = 2
);
  localparam int AW = $clog2(NREGS);
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*XLEN-1:0] rd_data;
  logic [NR-1:0]      rd_busy;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*XLEN-1:0] wr_data;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic [AW:0]        inflight_cnt;
  logic               pair_err;
`ifdef REGFILE_PAIR_EN
  logic               wr_pair;
  logic [XLEN-1:0]    wr_data_hi;
`endif
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
`ifdef REGFILE_PAIR_EN
    output wr_pair, wr_data_hi,
`endif
    input  rd_data, rd_busy, inflight_cnt, pair_err
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
`ifdef REGFILE_PAIR_EN
    input  wr_pair, wr_data_hi,
`endif
    output rd_data, rd_busy, inflight_cnt, pair_err
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read/NW-write register file with busy scoreboard; REGFILE_PAIR_EN enables 64-bit pair writes on port 0
module regfile_mp #(
  parameter int XLEN          = 32,
  parameter int NREGS         = 32,
  parameter int NR            = 3,
  parameter int NW            = 2,
  parameter bit WRITE_THROUGH = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0]  regs [NREGS];
  logic [XLEN-1:0]  wd [NREGS];
  logic [NREGS-1:0] we, busy, busy_nxt, alloc_vec;
  logic [AW:0]      cnt, n_set, n_clr;
  logic             pair_go;
`ifdef REGFILE_PAIR_EN
  logic pair_err_q;
  assign pair_go = bus.wr_en[0] & bus.wr_pair;
  // an odd-address pair write is dropped and flagged for the following cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pair_err_q <= 1'b0;
    else pair_err_q <= pair_go & bus.wr_addr[0];
  assign bus.pair_err = pair_err_q;
`else
  assign pair_go = 1'b0;
  assign bus.pair_err = 1'b0;
`endif
  // fold all write ports into per-register enable/data; later ports override earlier ones, x0 is never written
  always_comb begin
    we = '0;
    for (int r = 0; r < NREGS; r++) wd[r] = '0;
`ifdef REGFILE_PAIR_EN
    if (pair_go && !bus.wr_addr[0]) begin
      we[bus.wr_addr[AW-1:0]] = 1'b1;
      wd[bus.wr_addr[AW-1:0]] = bus.wr_data[XLEN-1:0];
      we[bus.wr_addr[AW-1:0] | AW'(1)] = 1'b1;
      wd[bus.wr_addr[AW-1:0] | AW'(1)] = bus.wr_data_hi;
    end
`endif
    for (int k = 0; k < NW; k++)
      if (bus.wr_en[k] && !(k == 0 && pair_go)) begin
        we[bus.wr_addr[k*AW +: AW]] = 1'b1;
        wd[bus.wr_addr[k*AW +: AW]] = bus.wr_data[k*XLEN +: XLEN];
      end
    we[0] = 1'b0;
  end
  // scoreboard next state: writes clear, allocs set and win over a same-cycle write
  always_comb begin
    alloc_vec = '0;
    if (bus.alloc_en && bus.alloc_addr != '0) alloc_vec[bus.alloc_addr] = 1'b1;
    busy_nxt = (busy & ~we) | alloc_vec;
    n_set = (AW+1)'($countones(busy_nxt & ~busy));
    n_clr = (AW+1)'($countones(busy & ~busy_nxt));
  end
  // storage, busy bits and incrementally maintained in-flight count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
      cnt <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) if (we[r]) regs[r] <= wd[r];
      busy <= busy_nxt;
      cnt <= cnt + n_set - n_clr;
    end
  assign bus.inflight_cnt = cnt;
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.rd_addr[i*AW +: AW];
    assign bus.rd_data[i*XLEN +: XLEN] = ra == '0 ? '0 :
                                         (WRITE_THROUGH && we[ra]) ? wd[ra] : regs[ra];
    assign bus.rd_busy[i] = busy[ra] & ~(WRITE_THROUGH && we[ra] && !alloc_vec[ra]);
  end
endmodule
